sys_bus_ctrl: RTL
=================

# sys_bus_ctrl

System bus slave that terminates the MMU master port and routes each single-word access either to main-memory SRAM or to the IO device port. It decodes the address, inserts the configured memory wait states and returns a one-cycle acknowledge with read data. It sits directly downstream of the MMU, driving the MMU's `m_ack` and `m_data_i` inputs.

## Interface

Parameters:
- `MEM_AW`, 16 — memory word-address width; `mem_addr = s_addr[MEM_AW+1:2]`.
- `MEM_WAIT`, 1 — memory wait states inserted before chip select, range 0–7.
- `IO_PAGE`, 20'h000FF — `s_addr[31:12]` value that selects the IO port.
- `IO_TIMEOUT`, 255 — IO wait limit in cycles, range 1–255. Used only with `BUS_TIMEOUT_EN`.

Ports:
- `clk`  in  1  — single clock. All logic is on the rising edge.
- `rst_n`  in  1  — reset, synchronous and active-low.
- `s_cyc`  in  1  — request from the MMU; held with the request fields until `s_ack`.
- `s_we`  in  1  — 1 = write.
- `s_strb`  in  4  — byte enables, memory only.
- `s_addr`  in  32  — byte address.
- `s_data_i`  in  32  — write data.
- `s_ack`  out  1  — one-cycle completion pulse.
- `s_data_o`  out  32  — read data, valid while `s_ack` = 1.
- `mem_cs`, `mem_we`  out  1 each — SRAM strobe and write enable.
- `mem_be`  out  4  — SRAM byte enables.
- `mem_addr`  out  `MEM_AW`  — SRAM word address.
- `mem_wdata`  out  32  — SRAM write data.
- `mem_rdata`  in  32  — SRAM read data; valid one cycle after `mem_cs`.
- `io_dev_req`, `io_dev_we`  out  1 each — IO request and write enable.
- `io_dev_addr`  out  12  — `s_addr[11:0]`.
- `io_dev_wdata`  out  32  — IO write data.
- `io_dev_rdata`  in  32  — IO read data.
- `io_dev_rdy`  in  1  — IO completion, sampled while `io_dev_req` = 1.
- `bus_err`  out  1  — sticky IO timeout flag.

## Operation

- The FSM has five states: IDLE, MEM_ACC, MEM_DONE, IO_WAIT, IO_DONE.
- IDLE with `s_cyc` = 1:
  - If `s_addr[31:12] == IO_PAGE`, go to IO_WAIT and clear the timeout counter.
  - Otherwise go to MEM_ACC and load the wait counter with `MEM_WAIT`.
- MEM_ACC:
  - While the counter is nonzero, decrement it and keep all `mem_*` strobes low.
  - When the counter is 0: `mem_cs` = 1 for exactly one cycle, `mem_we = s_we`, `mem_be = s_strb`, `mem_wdata = s_data_i`. Next state is MEM_DONE.
- MEM_DONE: `s_ack` = 1. For reads `s_data_o = mem_rdata`; for writes `s_data_o` = 0. Next state is IDLE.
- IO_WAIT:
  - `io_dev_req` = 1, with `io_dev_we`, `io_dev_addr` and `io_dev_wdata` driven from `s_*`.
  - On `io_dev_rdy` = 1, register `io_dev_rdata` (or 0 for a write) into `rdata_q` and go to IO_DONE.
  - `io_dev_rdy` in the first IO_WAIT cycle is accepted.
- IO_DONE: `s_ack` = 1 and `s_data_o = rdata_q`. Next state is IDLE.
- IDLE never acks. After every ack the block returns to IDLE, so a `s_cyc` still high on the next cycle is a new transaction. This matches the MMU advancing its address on `m_ack`.
- `s_strb` is ignored for IO; IO accesses are always a full word.
- `s_cyc` dropping mid-transaction does not abort the transaction; it completes and acks, and the master ignores that ack.
- `rst_n` = 0 in any state forces IDLE on the next edge. Counters, `rdata_q` and `bus_err` clear, and any in-flight transaction is dropped without an ack.
- Reset values: every output is 0, including `s_ack`, `s_data_o`, `mem_*`, `io_dev_*` and `bus_err`.

## Timing

- Memory access, with `s_cyc` first seen in IDLE at cycle 0:
  - `mem_cs` is high in cycle `MEM_WAIT + 1`.
  - `s_ack` is high in cycle `MEM_WAIT + 2`.
  - With `MEM_WAIT` = 0 the ack arrives at cycle 2.
- IO access, with `io_dev_rdy` first high in cycle k ≥ 1: `s_ack` is high in cycle k + 1.
- Back-to-back accesses: minimum spacing is one IDLE cycle after each ack, so a memory burst with `MEM_WAIT` = 0 runs at one word per 3 cycles.
- `s_ack` and `s_data_o` are driven from registered state only; there is no combinational path from `s_cyc` to `s_ack`.

## Configuration

- `BUS_TIMEOUT_EN` defined:
  - In IO_WAIT an 8-bit counter increments each cycle.
  - If it reaches `IO_TIMEOUT` without `io_dev_rdy`: `rdata_q` = 32'hDEAD_BEEF, `bus_err` sets (sticky until reset), and the next state is IO_DONE.
  - `io_dev_rdy` arriving in the same cycle as the timeout wins; `bus_err` is not set.
- `BUS_TIMEOUT_EN` undefined: IO_WAIT waits indefinitely, and `bus_err` is tied to 0.

## Test plan

- Memory read, `MEM_WAIT` = 1, `s_addr` = 32'h0000_0040, SRAM word 16 = 32'h1234_5678 -> `mem_cs` at cycle 2 with `mem_addr` = 16, `s_ack` at cycle 3 with `s_data_o` = 32'h1234_5678.
- Memory write, `s_strb` = 4'b0011, `s_data_i` = 32'hAABB_CCDD -> a single `mem_cs` pulse with `mem_we` = 1 and `mem_be` = 4'b0011; read-back of bytes 0–1 returns 16'hCCDD.
- 8-beat MMU-style burst (`s_cyc` held, address +4 after each ack) -> exactly 8 acks, one per 3 cycles with `MEM_WAIT` = 0, no duplicate `mem_cs`.
- IO read at 32'h000F_F010 with `io_dev_rdy` at cycle 4, rdata 32'h0000_00A5 -> `io_dev_addr` = 12'h010, `s_ack` at cycle 5 with `s_data_o` = 32'h0000_00A5.
- `BUS_TIMEOUT_EN`, `IO_TIMEOUT` = 10, `io_dev_rdy` never asserted -> ack with `s_data_o` = 32'hDEAD_BEEF and `bus_err` = 1 held until reset. Without the macro, no ack within 1000 cycles.
- `rst_n` low for one cycle during MEM_ACC -> no ack, all outputs 0 on the next cycle, and a new request afterwards completes normally.

Source files
------------

// File: rtl/sys_bus_ctrl.sv
// System bus slave: routes single-word MMU accesses to SRAM or the IO device port.
// Optional IO timeout with sticky bus_err is enabled by defining BUS_TIMEOUT_EN.
module sys_bus_ctrl #(
   parameter int unsigned MEM_AW     = 16,
   parameter int unsigned MEM_WAIT   = 1,
   parameter logic [19:0] IO_PAGE    = 20'h000FF,
   parameter int unsigned IO_TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              s_cyc,
   input  logic              s_we,
   input  logic [3:0]        s_strb,
   input  logic [31:0]       s_addr,
   input  logic [31:0]       s_data_i,
   output logic              s_ack,
   output logic [31:0]       s_data_o,
   output logic              mem_cs,
   output logic              mem_we,
   output logic [3:0]        mem_be,
   output logic [MEM_AW-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              io_dev_req,
   output logic              io_dev_we,
   output logic [11:0]       io_dev_addr,
   output logic [31:0]       io_dev_wdata,
   input  logic [31:0]       io_dev_rdata,
   input  logic              io_dev_rdy,
   output logic              bus_err
);

   typedef enum logic [2:0] {
      StIdle,
      StMemAcc,
      StMemDone,
      StIoWait,
      StIoDone
   } state_e;

   state_e      state_q, state_d;
   logic [2:0]  wait_q, wait_d;
   logic [31:0] rdata_q, rdata_d;

   logic unused_addr;
   assign unused_addr = ^s_addr[1:0];

`ifdef BUS_TIMEOUT_EN
   logic [7:0] to_q, to_d;
   logic       bus_err_q, bus_err_d;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         to_q      <= '0;
         bus_err_q <= 1'b0;
      end else begin
         to_q      <= to_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign bus_err = bus_err_q;
`else
   logic unused_cfg;
   assign unused_cfg = ^8'(IO_TIMEOUT);
   assign bus_err    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         wait_q  <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      wait_d       = wait_q;
      rdata_d      = rdata_q;
`ifdef BUS_TIMEOUT_EN
      to_d         = to_q;
      bus_err_d    = bus_err_q;
`endif
      s_ack        = 1'b0;
      s_data_o     = '0;
      mem_cs       = 1'b0;
      mem_we       = 1'b0;
      mem_be       = '0;
      mem_addr     = '0;
      mem_wdata    = '0;
      io_dev_req   = 1'b0;
      io_dev_we    = 1'b0;
      io_dev_addr  = '0;
      io_dev_wdata = '0;

      unique case (state_q)
         StIdle: begin
            if (s_cyc) begin
               if (s_addr[31:12] == IO_PAGE) begin
                  state_d = StIoWait;
`ifdef BUS_TIMEOUT_EN
                  to_d    = '0;
`endif
               end else begin
                  state_d = StMemAcc;
                  wait_d  = 3'(MEM_WAIT);
               end
            end
         end

         StMemAcc: begin
            if (wait_q != 3'd0) begin
               wait_d = wait_q - 3'd1;
            end else begin
               mem_cs    = 1'b1;
               mem_we    = s_we;
               mem_be    = s_strb;
               mem_addr  = s_addr[MEM_AW+1:2];
               mem_wdata = s_data_i;
               state_d   = StMemDone;
            end
         end

         StMemDone: begin
            s_ack    = 1'b1;
            s_data_o = s_we ? 32'h0 : mem_rdata;
            state_d  = StIdle;
         end

         StIoWait: begin
            io_dev_req   = 1'b1;
            io_dev_we    = s_we;
            io_dev_addr  = s_addr[11:0];
            io_dev_wdata = s_data_i;
            // A ready in the timeout cycle still wins over the timeout.
            if (io_dev_rdy) begin
               rdata_d = s_we ? 32'h0 : io_dev_rdata;
               state_d = StIoDone;
            end
`ifdef BUS_TIMEOUT_EN
            else begin
               to_d = to_q + 8'd1;
               if (to_q == 8'(IO_TIMEOUT - 1)) begin
                  rdata_d   = 32'hDEAD_BEEF;
                  bus_err_d = 1'b1;
                  state_d   = StIoDone;
               end
            end
`endif
         end

         StIoDone: begin
            s_ack    = 1'b1;
            s_data_o = rdata_q;
            state_d  = StIdle;
         end

         default: state_d = StIdle;
      endcase
   end

endmodule
